// File: rtl/keccak_stream_driver.sv
// Initiator-side front-end for the keccak/SHAKE core: config word, message absorb stream, digest squeeze FIFO.
// Optional cycle counter output (cycles_o) enabled by defining KECCAK_STREAM_DRIVER_PERF_EN.
module keccak_stream_driver #(
  parameter int W           = 64,
  parameter int DFIFO_DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cmd_valid_i,
  output logic         cmd_ready_o,
  input  logic [31:0]  cmd_in_bits_i,
  input  logic [27:0]  cmd_out_bits_i,
  input  logic         msg_valid_i,
  output logic         msg_ready_o,
  input  logic [W-1:0] msg_data_i,
  output logic         core_valid_o,
  input  logic         core_ready_i,
  output logic [W-1:0] core_data_o,
  input  logic         core_valid_i,
  output logic         core_ready_o,
  input  logic [W-1:0] core_data_i,
  output logic         dig_valid_o,
  input  logic         dig_ready_i,
  output logic [W-1:0] dig_data_o,
  output logic         dig_last_o,
  output logic         busy_o,
  output logic         done_o
`ifdef KECCAK_STREAM_DRIVER_PERF_EN
  ,
  output logic [31:0]  cycles_o
`endif
);

  localparam int KECCAK_W = 64;
  localparam int AW       = $clog2(DFIFO_DEPTH);
  localparam int SH       = $clog2(W);
  localparam logic [AW:0] DEPTH_L = (AW+1)'(DFIFO_DEPTH);

  generate
    if (W != KECCAK_W) begin : g_bad_width
      $error("keccak_stream_driver: W must equal the keccak word width (64)");
    end
    if (DFIFO_DEPTH < 2 || (DFIFO_DEPTH & (DFIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("keccak_stream_driver: DFIFO_DEPTH must be a power of two >= 2");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_CONFIG, S_STREAM, S_DONE} state_t;
  state_t state;

  logic [32:0]  in_words, out_words, msgs_sent, recv_cnt, dig_cnt;
  logic [AW:0]  wr_ptr, rd_ptr, fifo_cnt;
  logic [W-1:0] mem [DFIFO_DEPTH];

  logic fifo_full, fifo_empty;
  logic cmd_hs, msg_hs, core_hs, recv_hs, dig_hs;
  logic absorb_done_nxt, squeeze_done_nxt;
  logic [32:0] in_words_calc;
  logic [28:0] out_words_calc;

  always_comb begin
    fifo_cnt    = wr_ptr - rd_ptr;
    fifo_full   = (fifo_cnt == DEPTH_L);
    fifo_empty  = (wr_ptr == rd_ptr);
    cmd_ready_o = (state == S_IDLE);
    dig_valid_o = !fifo_empty;
    dig_data_o  = mem[rd_ptr[AW-1:0]];
    dig_last_o  = !fifo_empty && (dig_cnt == out_words - 33'd1);
    dig_hs      = dig_valid_o && dig_ready_i;
    // A full FIFO still accepts when the sink pops in the same cycle.
    core_ready_o = (state == S_STREAM) && (recv_cnt < out_words) && (!fifo_full || dig_hs);
    recv_hs      = core_valid_i && core_ready_o;
    core_hs      = core_valid_o && core_ready_i;
    msg_ready_o  = (state == S_STREAM) && ((msgs_sent + 33'(core_valid_o)) < in_words)
                   && (!core_valid_o || core_ready_i);
    msg_hs       = msg_valid_i && msg_ready_o;
    cmd_hs       = cmd_valid_i && cmd_ready_o;
    absorb_done_nxt  = (msgs_sent + 33'(core_hs)) == in_words;
    squeeze_done_nxt = (dig_cnt + 33'(dig_hs)) == out_words;
    in_words_calc    = ({1'b0, cmd_in_bits_i} + 33'(W - 1)) >> SH;
    out_words_calc   = ({1'b0, cmd_out_bits_i} + 29'(W - 1)) >> SH;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      in_words     <= '0;
      out_words    <= '0;
      msgs_sent    <= '0;
      recv_cnt     <= '0;
      dig_cnt      <= '0;
      core_valid_o <= 1'b0;
      core_data_o  <= '0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done_o <= 1'b0;
          if (cmd_hs) begin
            in_words     <= in_words_calc;
            out_words    <= {4'b0, out_words_calc};
            msgs_sent    <= '0;
            recv_cnt     <= '0;
            dig_cnt      <= '0;
            core_data_o  <= W'({4'b0, cmd_out_bits_i, cmd_in_bits_i});
            core_valid_o <= 1'b1;
            busy_o       <= 1'b1;
            state        <= S_CONFIG;
          end
        end
        S_CONFIG: begin
          if (core_hs) begin
            core_valid_o <= 1'b0;
            state        <= S_STREAM;
          end
        end
        S_STREAM: begin
          if (msg_hs) begin
            core_data_o  <= msg_data_i;
            core_valid_o <= 1'b1;
          end else if (core_hs) begin
            core_valid_o <= 1'b0;
          end
          if (core_hs) msgs_sent <= msgs_sent + 33'd1;
          if (recv_hs) recv_cnt  <= recv_cnt + 33'd1;
          if (dig_hs)  dig_cnt   <= dig_cnt + 33'd1;
          if (absorb_done_nxt && squeeze_done_nxt) begin
            done_o <= 1'b1;
            busy_o <= 1'b0;
            state  <= S_DONE;
          end
        end
        S_DONE: begin
          done_o <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (recv_hs) wr_ptr <= wr_ptr + 1'b1;
      if (dig_hs)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (recv_hs) mem[wr_ptr[AW-1:0]] <= core_data_i;
  end

`ifdef KECCAK_STREAM_DRIVER_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycles_o <= '0;
    end else if (cmd_hs) begin
      cycles_o <= '0;
    end else if ((state == S_CONFIG || state == S_STREAM) && cycles_o != '1) begin
      cycles_o <= cycles_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_keccak_stream_driver.sv
// Self-checking bench for keccak_stream_driver: table of directed commands, random commands, reset corner cases.
module tb_keccak_stream_driver;
  localparam int W     = 64;
  localparam int DEPTH = 2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         cmd_valid_i, cmd_ready_o;
  logic [31:0]  cmd_in_bits_i;
  logic [27:0]  cmd_out_bits_i;
  logic         msg_valid_i, msg_ready_o;
  logic [W-1:0] msg_data_i;
  logic         core_valid_o, core_ready_i;
  logic [W-1:0] core_data_o;
  logic         core_valid_i, core_ready_o;
  logic [W-1:0] core_data_i;
  logic         dig_valid_o, dig_ready_i, dig_last_o;
  logic [W-1:0] dig_data_o;
  logic         busy_o, done_o;

  always #5 clk = ~clk;

  keccak_stream_driver #(.W(W), .DFIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_in_bits_i(cmd_in_bits_i), .cmd_out_bits_i(cmd_out_bits_i),
    .msg_valid_i(msg_valid_i), .msg_ready_o(msg_ready_o), .msg_data_i(msg_data_i),
    .core_valid_o(core_valid_o), .core_ready_i(core_ready_i), .core_data_o(core_data_o),
    .core_valid_i(core_valid_i), .core_ready_o(core_ready_o), .core_data_i(core_data_i),
    .dig_valid_o(dig_valid_o), .dig_ready_i(dig_ready_i), .dig_data_o(dig_data_o),
    .dig_last_o(dig_last_o), .busy_o(busy_o), .done_o(done_o)
  );

  typedef struct {
    int          in_bits;
    int          out_bits;
    logic [63:0] exp_cfg;
    int          exp_in;
    int          exp_out;
    int          p_msg;
    int          p_core;
    int          p_sink;
    int          stall;
  } vec_t;

  int n_cmp = 0;
  int n_err = 0;

  logic [63:0] msg_exp[$], msg_q[$], dig_exp[$], dq[$];
  logic [63:0] core_rx[$], src_acc[$], sink_q[$];
  bit          sink_last[$];
  int  p_msg, p_core, p_sink, stall_left, exp_in, exp_out, done_cnt;
  bit  active, cmd_pend, saw_msg_ready, saw_core_ready, saw_dig_valid;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bit chance(input int p);
    return $urandom_range(0, 99) < p;
  endfunction

  // One clock: drive inputs after the falling edge, then predict the handshakes of the next rising edge.
  task automatic step();
    @(negedge clk);
    cmd_valid_i  = cmd_pend;
    msg_valid_i  = (msg_q.size() > 0) && chance(p_msg);
    msg_data_i   = (msg_q.size() > 0) ? msg_q[0] : {$urandom, $urandom};
    core_ready_i = chance(p_core);
    core_valid_i = active && (core_rx.size() == exp_in + 1) && (dq.size() > 0) && chance(p_core);
    core_data_i  = (dq.size() > 0) ? dq[0] : '0;
    if (stall_left > 0) begin
      dig_ready_i = 1'b0;
      stall_left--;
    end else begin
      dig_ready_i = chance(p_sink);
    end
    #1;
    if (msg_ready_o)  saw_msg_ready  = 1'b1;
    if (core_ready_o) saw_core_ready = 1'b1;
    if (dig_valid_o)  saw_dig_valid  = 1'b1;
    if (done_o) done_cnt++;
    if (cmd_valid_i && cmd_ready_o) cmd_pend = 1'b0;
    if (msg_valid_i && msg_ready_o) void'(msg_q.pop_front());
    if (core_valid_o && core_ready_i) core_rx.push_back(core_data_o);
    if (core_valid_i && core_ready_o) begin
      src_acc.push_back(core_data_i);
      void'(dq.pop_front());
    end
    if (dig_valid_o && dig_ready_i) begin
      sink_q.push_back(dig_data_o);
      sink_last.push_back(dig_last_o);
    end
  endtask

  task automatic setup_cmd(input vec_t v);
    msg_exp.delete(); dig_exp.delete(); core_rx.delete(); src_acc.delete();
    sink_q.delete(); sink_last.delete();
    for (int i = 0; i < v.exp_in; i++) msg_exp.push_back({$urandom, $urandom});
    for (int i = 0; i < v.exp_out + 3; i++) dig_exp.push_back({$urandom, $urandom});
    msg_q = msg_exp;
    dq    = dig_exp;
    exp_in = v.exp_in;  exp_out = v.exp_out;
    p_msg = v.p_msg;    p_core = v.p_core;  p_sink = v.p_sink;
    stall_left = v.stall;
    cmd_in_bits_i  = 32'(v.in_bits);
    cmd_out_bits_i = 28'(v.out_bits);
    done_cnt = 0;
    saw_msg_ready = 1'b0; saw_core_ready = 1'b0; saw_dig_valid = 1'b0;
    cmd_pend = 1'b1;
    active   = 1'b1;
  endtask

  task automatic run_cmd(input string tag, input vec_t v);
    int  cyc, acc_cyc, lasts;
    bit  ok, stall_chk;
    setup_cmd(v);
    cyc = 0; acc_cyc = -1; stall_chk = (v.stall > 0);
    while (done_cnt == 0 && cyc < 4000) begin
      step();
      cyc++;
      if (cyc == acc_cyc + 1 && acc_cyc >= 0) begin
        check({tag, " busy after accept"}, 64'(busy_o), 64'd1);
        check({tag, " cfg presented"}, core_data_o, v.exp_cfg);
      end
      if (acc_cyc < 0 && !cmd_pend) acc_cyc = cyc;
      if (stall_chk && stall_left == 0) begin
        stall_chk = 1'b0;
        check({tag, " fifo fill"}, 64'(src_acc.size()), 64'(DEPTH));
        check({tag, " core_ready when full"}, 64'(core_ready_o), 64'd0);
      end
    end
    if (done_cnt == 0) check({tag, " timeout"}, 64'd1, 64'd0);
    repeat (3) step();
    active = 1'b0;
    check({tag, " cfg word"}, (core_rx.size() > 0) ? core_rx[0] : '1, v.exp_cfg);
    check({tag, " core words"}, 64'(core_rx.size()), 64'(v.exp_in + 1));
    ok = (core_rx.size() == v.exp_in + 1);
    for (int i = 0; i < v.exp_in && ok; i++) if (core_rx[i+1] !== msg_exp[i]) ok = 1'b0;
    check({tag, " msg order"}, 64'(ok), 64'd1);
    check({tag, " digest count"}, 64'(sink_q.size()), 64'(v.exp_out));
    check({tag, " core accepted"}, 64'(src_acc.size()), 64'(v.exp_out));
    ok = (sink_q.size() == v.exp_out);
    lasts = 0;
    for (int i = 0; i < sink_q.size(); i++) begin
      if (sink_q[i] !== dig_exp[i]) ok = 1'b0;
      if (sink_last[i]) lasts++;
    end
    check({tag, " digest order"}, 64'(ok), 64'd1);
    check({tag, " last count"}, 64'(lasts), 64'((v.exp_out > 0) ? 1 : 0));
    if (v.exp_out > 0 && sink_last.size() > 0)
      check({tag, " last on final"}, 64'(sink_last[sink_last.size()-1]), 64'd1);
    check({tag, " done pulses"}, 64'(done_cnt), 64'd1);
    check({tag, " idle ready"}, {62'd0, cmd_ready_o, busy_o}, 64'b10);
    if (v.exp_in == 0) check({tag, " msg_ready never"}, 64'(saw_msg_ready), 64'd0);
    if (v.exp_out == 0) begin
      check({tag, " core_ready never"}, 64'(saw_core_ready), 64'd0);
      check({tag, " dig_valid never"}, 64'(saw_dig_valid), 64'd0);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " rst handshake outs"},
          {58'd0, cmd_ready_o, core_valid_o, core_ready_o, msg_ready_o, dig_valid_o, dig_last_o},
          64'b100000);
    check({tag, " rst busy/done"}, {62'd0, busy_o, done_o}, 64'd0);
    check({tag, " rst core_data"}, core_data_o, 64'd0);
  endtask

  vec_t tbl[8];

  initial begin
    vec_t v;
    int   ib, ob, guard;
    tbl[0] = '{1088, 256, 64'h0000_0100_0000_0440, 17, 4, 100, 100, 100, 0};
    tbl[1] = '{0,     64, 64'h0000_0040_0000_0000, 0,  1, 100, 100, 100, 0};
    tbl[2] = '{100,    0, 64'h0000_0000_0000_0064, 2,  0, 100, 100, 100, 0};
    tbl[3] = '{64,   512, 64'h0000_0200_0000_0040, 1,  8, 100, 100, 100, 20};
    tbl[4] = '{65,    65, 64'h0000_0041_0000_0041, 2,  2, 60,  50,  40,  0};
    tbl[5] = '{0,      0, 64'h0000_0000_0000_0000, 0,  0, 100, 100, 100, 0};
    tbl[6] = '{1344, 1344, 64'h0000_0540_0000_0540, 21, 21, 50, 50, 50, 0};
    tbl[7] = '{127,   63, 64'h0000_003F_0000_007F, 2,  1, 70,  30,  80,  0};

    rst_n = 1'b0;
    cmd_valid_i = 1'b0; cmd_in_bits_i = '0; cmd_out_bits_i = '0;
    msg_valid_i = 1'b0; msg_data_i = '0; core_ready_i = 1'b0;
    core_valid_i = 1'b0; core_data_i = '0; dig_ready_i = 1'b0;
    active = 1'b0; cmd_pend = 1'b0; stall_left = 0; exp_in = 0; exp_out = 0;
    p_msg = 0; p_core = 0; p_sink = 0;
    #12;
    check_reset_outputs("init");
    @(negedge clk) rst_n = 1'b1;

    for (int i = 0; i < 8; i++) run_cmd($sformatf("vec%0d", i), tbl[i]);

    for (int k = 0; k < 6; k++) begin
      ib = $urandom_range(0, 800);
      ob = $urandom_range(0, 800);
      v.in_bits  = ib;
      v.out_bits = ob;
      v.exp_cfg  = {4'b0, 28'(ob), 32'(ib)};
      v.exp_in   = (ib + W - 1) / W;
      v.exp_out  = (ob + W - 1) / W;
      v.p_msg    = $urandom_range(30, 100);
      v.p_core   = $urandom_range(30, 100);
      v.p_sink   = $urandom_range(30, 100);
      v.stall    = 0;
      run_cmd($sformatf("rnd%0d", k), v);
    end

    // Reset in the middle of a long absorb, then a fresh command must run cleanly.
    setup_cmd(tbl[0]);
    guard = 0;
    while (core_rx.size() < 4 && guard < 200) begin
      step();
      guard++;
    end
    check("midrst reached", 64'(core_rx.size()), 64'd4);
    @(negedge clk) rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    active = 1'b0; cmd_pend = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    v = '{64, 64, 64'h0000_0040_0000_0040, 1, 1, 100, 100, 100, 0};
    run_cmd("post_rst", v);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
